// File: rtl/sensor_conditioner.sv
// Sensor front end: 2-FF synchronised, debounced door/window/fire lines and a
// stability-filtered, slew-limited temperature. Optional macro: FIRE_FASTPATH_EN.
module sensor_conditioner #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned TEMP_STABLE = 4,
  parameter int unsigned MAX_STEP    = 10
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_w,
  input  logic       raw_fa,
  input  logic [6:0] raw_temp,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [6:0] ST,
  output logic       temp_valid,
  output logic       evt
);

  localparam int unsigned N_CH   = 4;
  localparam int unsigned CNT_W  = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned TCNT_W = $clog2(TEMP_STABLE) + 1;
  localparam int unsigned FA_IDX = 3;

  logic [N_CH-1:0]            r_s1;
  logic [N_CH-1:0]            r_s2;
  logic [N_CH-1:0]            r_out;
  logic [N_CH-1:0][CNT_W-1:0] r_cnt;
  logic                       r_evt;
  logic [6:0]                 r_tcap;
  logic [TCNT_W-1:0]          r_tcnt;
  logic [6:0]                 r_st;
  logic                       r_valid;

  logic [N_CH-1:0]            w_raw;
  logic [N_CH-1:0]            w_out_nxt;
  logic [N_CH-1:0]            w_flip;
  logic [N_CH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic                       w_match;
  logic                       w_update;
  logic                       w_up;
  logic [6:0]                 w_diff;
  logic [6:0]                 w_st_nxt;

  assign w_raw = {raw_fa, raw_w, raw_rd, raw_fd};

  // Per-channel debounce: flip only after DEB_CYCLES consecutive mismatching edges.
  always_comb begin
    w_out_nxt = r_out;
    w_flip    = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (r_s2[i] != r_out[i]) begin
        if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          w_out_nxt[i] = r_s2[i];
          w_flip[i]    = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
`ifdef FIRE_FASTPATH_EN
    // Fire alarm asserts immediately once synchronised; release stays debounced.
    if (r_s2[FA_IDX] && !r_out[FA_IDX]) begin
      w_out_nxt[FA_IDX] = 1'b1;
      w_flip[FA_IDX]    = 1'b1;
      w_cnt_nxt[FA_IDX] = '0;
    end
`endif
  end

  // Temperature acceptance and slew toward the captured value.
  always_comb begin
    w_match  = (raw_temp == r_tcap);
    w_update = w_match && (r_tcnt == TCNT_W'(TEMP_STABLE - 1));
    w_up     = (r_tcap > r_st);
    w_diff   = w_up ? (r_tcap - r_st) : (r_st - r_tcap);
    w_st_nxt = r_st;
    if (!r_valid) begin
      w_st_nxt = r_tcap;
    end else if (w_diff > 7'(MAX_STEP)) begin
      w_st_nxt = w_up ? (r_st + 7'(MAX_STEP)) : (r_st - 7'(MAX_STEP));
    end else begin
      w_st_nxt = r_tcap;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
      r_tcap  <= '0;
      r_tcnt  <= '0;
      r_st    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_out  <= w_out_nxt;
      r_cnt  <= w_cnt_nxt;
      r_evt  <= |w_flip;
      r_tcap <= raw_temp;
      if (w_update) begin
        r_tcnt  <= '0;
        r_st    <= w_st_nxt;
        r_valid <= 1'b1;
      end else if (w_match) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end else begin
        r_tcnt <= '0;
      end
    end
  end

  assign SFD        = r_out[0];
  assign SRD        = r_out[1];
  assign SW         = r_out[2];
  assign SFA        = r_out[FA_IDX];
  assign ST         = r_st;
  assign temp_valid = r_valid;
  assign evt        = r_evt;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: directed plan steps plus random
// stimulus against a streak-counting reference model.
module tb_sensor_conditioner;

  localparam int DEB = 4;
  localparam int TS  = 4;
  localparam int MS  = 10;
`ifdef FIRE_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Rst;
  logic [3:0] raw;
  logic [6:0] raw_temp;
  logic       SFD, SRD, SW, SFA, temp_valid, evt;
  logic [6:0] ST;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [12:0] exp_q[$];

  sensor_conditioner dut (
    .clk(clk), .Rst(Rst),
    .raw_fd(raw[0]), .raw_rd(raw[1]), .raw_w(raw[2]), .raw_fa(raw[3]),
    .raw_temp(raw_temp),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA),
    .ST(ST), .temp_valid(temp_valid), .evt(evt)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples reach the debouncer two edges late; a line
  // flips after DEB consecutive disagreeing edges, temperature is accepted
  // after TS consecutive equal samples and then moves at most MS per update.
  logic [3:0] m_old, m_new, m_out;
  int         m_run[4];
  logic       m_evt, m_valid;
  logic [6:0] m_tcap;
  int         m_stable, m_st;

  task automatic model_edge(input logic rst, input logic [3:0] r, input logic [6:0] t);
    logic [3:0] s2;
    int d;
    if (!rst) begin
      m_old = '0; m_new = '0; m_out = '0; m_evt = 1'b0; m_valid = 1'b0;
      m_tcap = '0; m_stable = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      s2 = m_old;
      m_evt = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (FAST && i == 3 && s2[i] && !m_out[i]) begin
          m_out[i] = 1'b1; m_run[i] = 0; m_evt = 1'b1;
        end else if (s2[i] != m_out[i]) begin
          m_run[i]++;
          if (m_run[i] >= DEB) begin
            m_out[i] = s2[i]; m_run[i] = 0; m_evt = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_old = m_new;
      m_new = r;
      if (t == m_tcap) begin
        m_stable++;
        if (m_stable >= TS) begin
          m_stable = 0;
          if (!m_valid) begin
            m_st = int'(m_tcap); m_valid = 1'b1;
          end else begin
            d = int'(m_tcap) - m_st;
            if (d > MS) m_st += MS;
            else if (d < -MS) m_st -= MS;
            else m_st = int'(m_tcap);
          end
        end
      end else begin
        m_stable = 0;
      end
      m_tcap = t;
    end
  endtask

  // Drive one edge's inputs at the falling edge and queue the expected outputs.
  task automatic tick(input logic rst, input logic [3:0] r, input logic [6:0] t);
    @(negedge clk);
    Rst = rst; raw = r; raw_temp = t;
    model_edge(rst, r, t);
    exp_q.push_back({m_out[0], m_out[1], m_out[2], m_out[3], 7'(m_st), m_valid, m_evt});
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic spot(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    logic [12:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {SFD, SRD, SW, SFA, ST, temp_valid, evt};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs@cycle%0d: got {SFD,SRD,SW,SFA,ST,tv,evt}=%b_%0d_%b_%b, required %b_%0d_%b_%b",
                   cyc, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] rb;
    logic [6:0] rt;
    Rst = 1'b0; raw = '0; raw_temp = '0;

    // Reset with every raw input high.
    tick(1'b0, 4'hF, 7'd90);
    tick(1'b0, 4'hF, 7'd90);
    after_edge();
    spot("reset_state", int'({SFD, SRD, SW, SFA, ST, temp_valid, evt}), 0);

    // Front door debounce and first temperature acceptance together.
    for (int k = 0; k <= 6; k++) begin
      tick(1'b1, 4'b0001, 7'd25);
      after_edge();
      if (k == 3) spot("tv_before_edge4", int'(temp_valid), 0);
      if (k == 4) begin
        spot("first_st", int'(ST), 25);
        spot("first_tv", int'(temp_valid), 1);
        spot("sfd_edge4", int'(SFD), 0);
      end
      if (k == 5) begin
        spot("sfd_edge5", int'(SFD), 1);
        spot("evt_edge5", int'(evt), 1);
      end
      if (k == 6) spot("evt_edge6", int'(evt), 0);
    end

    // Upward slew 25 -> 60.
    for (int k = 0; k <= 16; k++) begin
      tick(1'b1, 4'b0001, 7'd60);
      after_edge();
      if (k == 4)  spot("slew_35", int'(ST), 35);
      if (k == 8)  spot("slew_45", int'(ST), 45);
      if (k == 12) spot("slew_55", int'(ST), 55);
      if (k == 16) spot("slew_60", int'(ST), 60);
    end

    // Small downward step is applied in one update.
    for (int k = 0; k <= 5; k++) begin
      tick(1'b1, 4'b0001, 7'd52);
      after_edge();
      if (k == 3) spot("down_hold", int'(ST), 60);
      if (k == 4) spot("down_52", int'(ST), 52);
    end

    // Window glitch of 3 cycles is rejected; 4 cycles is accepted.
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, (k < 3) ? 4'b0101 : 4'b0001, 7'd52);
      after_edge();
      spot("glitch3_sw", int'(SW), 0);
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, (k < 4) ? 4'b0101 : 4'b0001, 7'd52);
      after_edge();
      if (k == 4) spot("pulse4_sw_edge4", int'(SW), 0);
      if (k == 5) spot("pulse4_sw_edge5", int'(SW), 1);
    end

    // Simultaneous front door and fire alarm rise after a fresh reset.
    tick(1'b0, 4'h0, 7'd0);
    tick(1'b0, 4'h0, 7'd0);
    for (int k = 0; k <= 7; k++) begin
      tick(1'b1, 4'b1001, 7'd40);
      after_edge();
      if (k == 2) spot("sfa_edge2", int'(SFA), FAST ? 1 : 0);
      if (k == 5) begin
        spot("sfd_sim_edge5", int'(SFD), 1);
        spot("sfa_sim_edge5", int'(SFA), 1);
      end
    end

    // Randomised stimulus with held values and occasional resets.
    rb = 4'b1001; rt = 7'd40;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      if ($urandom_range(0, 9) == 0) rt = 7'($urandom_range(0, 127));
      tick(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rb, rt);
    end

    after_edge();
    repeat (2) after_edge();
    spot("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
